kab_int_controller: RTL

- Interrupt controller between the SystemChip external request pins and the Kabeta CPU core.
- Synchronises eight maskable requests, IntReq[7:0], and one non-maskable UrgentReq, and latches their rising edges as pending.
- Arbitrates the pending requests and presents one interrupt ID at a time to the CPU.
- Uses an assert/acknowledge/end-of-interrupt handshake; one interrupt is in service at a time, with no nesting.

---
 rtl/kab_int_controller_if.sv | 24 ++
 rtl/kab_int_controller.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/kab_int_controller_if.sv
// Bus bundle between the Kabeta interrupt controller and its surroundings:
// the external request pins, the mask write port and the CPU assert/ack/EOI handshake.
interface kab_int_controller_if;
   logic [7:0] int_req;
   logic       urgent_req;
   logic       mask_we;
   logic [7:0] mask_data;
   logic [7:0] int_mask;
   logic [8:0] pending;
   logic       irq;
   logic [3:0] int_id;
   logic       int_ack;
   logic       int_eoi;

   modport master (
      output int_req, urgent_req, mask_we, mask_data, int_ack, int_eoi,
      input  int_mask, pending, irq, int_id
   );

   modport slave (
      input  int_req, urgent_req, mask_we, mask_data, int_ack, int_eoi,
      output int_mask, pending, irq, int_id
   );
endinterface

// File: rtl/kab_int_controller.sv
// Kabeta interrupt controller: synchronises 8 maskable + 1 urgent request, latches edges, serves one at a time.
// Optional macro KAB_INTC_ROUND_ROBIN_EN selects rotating priority among the maskable sources.
//
// state     | meaning
// ----------+--------------------------------------------------
// S_IDLE    | nothing presented; arbitrate eligible pending bits
// S_REQ     | irq high, int_id presented, waiting for int_ack
// S_SERVICE | acknowledged, int_id held, waiting for int_eoi
module kab_int_controller #(
   parameter int NUM_SRC     = 8,
   parameter int SYNC_STAGES = 2
) (
   input logic              clk,
   input logic              rst_n,
   kab_int_controller_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_REQ     = 2'd1,
      S_SERVICE = 2'd2
   } state_t;

   logic [NUM_SRC:0]   sync_q [SYNC_STAGES];
   logic [NUM_SRC:0]   prev_q;
   logic [NUM_SRC:0]   edge_det;
   logic [NUM_SRC-1:0] mask_q;
   logic [NUM_SRC:0]   pend_q, pend_d, pend_clr;
   logic [NUM_SRC:0]   cand;
   state_t             state_q, state_d;
   logic               irq_q, irq_d;
   logic [3:0]         id_q, id_d;
   logic               win_vld;
   logic [3:0]         win_id;
`ifdef KAB_INTC_ROUND_ROBIN_EN
   logic [2:0]         ptr_q, ptr_d;
   logic [2:0]         idx;
`endif

   // Bit NUM_SRC carries the urgent line alongside the maskable ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
         prev_q <= '0;
      end else begin
         sync_q[0] <= {bus.urgent_req, bus.int_req};
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign edge_det = sync_q[SYNC_STAGES-1] & ~prev_q;
   assign pend_d   = (pend_q & ~pend_clr) | edge_det;
   assign cand     = {pend_q[NUM_SRC], pend_q[NUM_SRC-1:0] & mask_q};

   always_comb begin
      win_vld = 1'b0;
      win_id  = '0;
`ifdef KAB_INTC_ROUND_ROBIN_EN
      idx     = '0;
`endif
      if (cand[NUM_SRC]) begin
         win_vld = 1'b1;
         win_id  = 4'd8;
      end else begin
         for (int i = 0; i < NUM_SRC; i++) begin
`ifdef KAB_INTC_ROUND_ROBIN_EN
            idx = ptr_q + 3'(i);
            if (!win_vld && cand[idx]) begin
               win_vld = 1'b1;
               win_id  = {1'b0, idx};
            end
`else
            if (!win_vld && cand[i]) begin
               win_vld = 1'b1;
               win_id  = 4'(i);
            end
`endif
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      irq_d    = irq_q;
      id_d     = id_q;
      pend_clr = '0;
`ifdef KAB_INTC_ROUND_ROBIN_EN
      ptr_d    = ptr_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (win_vld) begin
               id_d    = win_id;
               irq_d   = 1'b1;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            // A simultaneous EOI is dropped; the ack alone moves us on.
            if (bus.int_ack) begin
               pend_clr[id_q] = 1'b1;
               irq_d          = 1'b0;
               state_d        = S_SERVICE;
`ifdef KAB_INTC_ROUND_ROBIN_EN
               if (!id_q[3]) ptr_d = id_q[2:0] + 3'd1;
`endif
            end
         end
         S_SERVICE: begin
            if (bus.int_eoi) state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            irq_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         irq_q   <= 1'b0;
         id_q    <= '0;
         pend_q  <= '0;
         mask_q  <= '0;
`ifdef KAB_INTC_ROUND_ROBIN_EN
         ptr_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         irq_q   <= irq_d;
         id_q    <= id_d;
         pend_q  <= pend_d;
         if (bus.mask_we) mask_q <= bus.mask_data;
`ifdef KAB_INTC_ROUND_ROBIN_EN
         ptr_q   <= ptr_d;
`endif
      end
   end

   assign bus.int_mask = mask_q;
   assign bus.pending  = pend_q;
   assign bus.irq      = irq_q;
   assign bus.int_id   = id_q;

endmodule
